// File: rtl/fb_pkg.sv
// ============================================================================
// fb_pkg : shared constants, op codes and state type for the draw engine
// Rev 1.0
// ============================================================================
`default_nettype none

package fb_pkg;

  localparam int FB_W  = 128;
  localparam int FB_H  = 64;
  localparam int FB_AW = 13;
  localparam int FB_XW = 7;
  localparam int FB_YW = 6;

  typedef enum logic [1:0] {
    OP_PLOT  = 2'd0,
    OP_FILL  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// sync_2ff : 1-bit two-flop synchroniser for a level from another clock domain
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

`default_nettype wire

// File: rtl/fb_draw_engine.sv
// ============================================================================
// fb_draw_engine : plot / fill / clear commands -> one frame buffer write per
// cycle in row-major order. Optional FB_DRAW_VBLANK_GATE_EN holds writes
// outside vertical blanking.
// Rev 1.0
// ============================================================================
`default_nettype none

module fb_draw_engine #(
  parameter int FB_W = fb_pkg::FB_W,
  parameter int FB_H = fb_pkg::FB_H
) (
  input  logic                     I_clk,
  input  logic                     I_rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [fb_pkg::FB_XW-1:0] cmd_x0,
  input  logic [fb_pkg::FB_XW-1:0] cmd_x1,
  input  logic [fb_pkg::FB_YW-1:0] cmd_y0,
  input  logic [fb_pkg::FB_YW-1:0] cmd_y1,
  input  logic [1:0]               cmd_colour,
  input  logic                     I_vblank,
  output logic [fb_pkg::FB_AW-1:0] ADDRESS,
  output logic                     IE,
  output logic [1:0]               COLOUR,
  output logic                     busy
);

  import fb_pkg::*;

  localparam logic [FB_XW-1:0] X_LAST = FB_XW'(FB_W - 1);
  localparam logic [FB_YW-1:0] Y_LAST = FB_YW'(FB_H - 1);

  state_e            state_q, state_d;
  logic [FB_XW-1:0]  x_q, x_d;
  logic [FB_YW-1:0]  y_q, y_d;
  logic [FB_XW-1:0]  xmin_q, xmin_d;
  logic [FB_XW-1:0]  xmax_q, xmax_d;
  logic [FB_YW-1:0]  ymax_q, ymax_d;
  logic [1:0]        colour_q, colour_d;
  logic              ie_q, ie_d;

  op_e               op;
  logic [FB_XW-1:0]  bx_min, bx_max;
  logic [FB_YW-1:0]  by_min, by_max;
  logic              last_px;
  logic              draw_gate;

`ifdef FB_DRAW_VBLANK_GATE_EN
  logic vb_s;

  sync_2ff u_vb_sync (
    .clk (I_clk),
    .rst (I_rst),
    .i_d (I_vblank),
    .o_q (vb_s)
  );

  // IE is registered from vb_s, so a vblank rise sampled at M writes at M+2
  assign draw_gate = vb_s;
`else
  logic vblank_unused;
  assign vblank_unused = I_vblank;
  assign draw_gate     = 1'b1;
`endif

  assign op = op_e'(cmd_op);

  always_comb begin
    bx_min = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
    bx_max = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
    by_min = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
    by_max = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
    case (op)
      OP_PLOT: begin
        bx_min = cmd_x0;
        bx_max = cmd_x0;
        by_min = cmd_y0;
        by_max = cmd_y0;
      end
      OP_CLEAR: begin
        bx_min = '0;
        bx_max = X_LAST;
        by_min = '0;
        by_max = Y_LAST;
      end
      default: ;
    endcase
  end

  assign last_px = (x_q == xmax_q) && (y_q == ymax_q);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    xmin_d   = xmin_q;
    xmax_d   = xmax_q;
    ymax_d   = ymax_q;
    colour_d = colour_q;
    ie_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          colour_d = cmd_colour;
          if (op != OP_RSVD) begin
            state_d = DRAW;
            x_d     = bx_min;
            y_d     = by_min;
            xmin_d  = bx_min;
            xmax_d  = bx_max;
            ymax_d  = by_max;
            ie_d    = draw_gate;
          end
        end
      end
      DRAW: begin
        ie_d = draw_gate;
        // The pixel on ADDRESS only retires when it was actually written
        if (ie_q) begin
          if (last_px) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
            ie_d    = 1'b0;
          end else if (x_q < xmax_q) begin
            x_d = x_q + 1'b1;
          end else begin
            x_d = xmin_q;
            y_d = y_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      xmin_q   <= '0;
      xmax_q   <= '0;
      ymax_q   <= '0;
      colour_q <= '0;
      ie_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      xmin_q   <= xmin_d;
      xmax_q   <= xmax_d;
      ymax_q   <= ymax_d;
      colour_q <= colour_d;
      ie_q     <= ie_d;
    end
  end

  // Counters are parked at zero outside DRAW, so ADDRESS is a plain concat
  assign ADDRESS   = {y_q, x_q};
  assign IE        = ie_q;
  assign COLOUR    = colour_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == DRAW);

endmodule

`default_nettype wire

// File: tb/tb_fb_draw_engine.sv
// ============================================================================
// tb_fb_draw_engine : randomized scoreboard bench for fb_draw_engine
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fb_draw_engine;

  localparam int W = 128;
  localparam int H = 64;
  localparam int BOUND = 20000;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [6:0]  cmd_x0 = '0, cmd_x1 = '0;
  logic [5:0]  cmd_y0 = '0, cmd_y1 = '0;
  logic [1:0]  cmd_colour = '0;
  logic        I_vblank = 1'b1;
  logic [12:0] ADDRESS;
  logic        IE;
  logic [1:0]  COLOUR;
  logic        busy;

  fb_draw_engine #(.FB_W(W), .FB_H(H)) dut (
    .I_clk      (I_clk),
    .I_rst      (I_rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_x0     (cmd_x0),
    .cmd_x1     (cmd_x1),
    .cmd_y0     (cmd_y0),
    .cmd_y1     (cmd_y1),
    .cmd_colour (cmd_colour),
    .I_vblank   (I_vblank),
    .ADDRESS    (ADDRESS),
    .IE         (IE),
    .COLOUR     (COLOUR),
    .busy       (busy)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    int addr;
    int col;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_cmp = 0;
  int  n_err = 0;
  bit  mon_en = 1'b0;
  bit  chk_ie_busy = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Reference model: enumerate the pixels a command covers, row-major
  task automatic model_push(input int op, input int x0, input int x1,
                            input int y0, input int y1, input int col,
                            output int n);
    int xa, xb, ya, yb;
    n = 0;
    case (op)
      0: begin xa = x0; xb = x0; ya = y0; yb = y0; end
      1: begin
        xa = (x0 < x1) ? x0 : x1;  xb = (x0 < x1) ? x1 : x0;
        ya = (y0 < y1) ? y0 : y1;  yb = (y0 < y1) ? y1 : y0;
      end
      2: begin xa = 0; xb = W - 1; ya = 0; yb = H - 1; end
      default: return;
    endcase
    for (int y = ya; y <= yb; y++)
      for (int x = xa; x <= xb; x++) begin
        exp_q.push_back('{addr: y * W + x, col: col});
        n++;
      end
  endtask

  always @(negedge I_clk) begin
    if (mon_en) begin
      if (chk_ie_busy)
        check("ie_equals_busy", int'(IE), int'(busy));
      if (IE === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got address %0d, no write expected", ADDRESS);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_addr", int'(ADDRESS), mon_e.addr);
          check("write_colour", int'(COLOUR), mon_e.col);
        end
      end
    end
  end

  task automatic wait_ready();
    int g = 0;
    while (cmd_ready !== 1'b1 && g < BOUND) begin
      @(posedge I_clk); #1;
      g++;
    end
    if (cmd_ready !== 1'b1) check("ready_timeout", 0, 1);
  endtask

  task automatic drive(input int op, input int x0, input int x1,
                       input int y0, input int y1, input int col);
    cmd_op = op[1:0];
    cmd_x0 = x0[6:0];
    cmd_x1 = x1[6:0];
    cmd_y0 = y0[5:0];
    cmd_y1 = y1[5:0];
    cmd_colour = col[1:0];
    cmd_valid = 1'b1;
  endtask

  task automatic scramble();
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom);
    cmd_x0 = 7'($urandom);
    cmd_x1 = 7'($urandom);
    cmd_y0 = 6'($urandom);
    cmd_y1 = 6'($urandom);
    cmd_colour = 2'($urandom);
  endtask

  // Issue one command, then check busy length and that every write appeared
  task automatic send(input int op, input int x0, input int x1,
                      input int y0, input int y1, input int col);
    int n, bc, g;
    wait_ready();
    drive(op, x0, x1, y0, y1, col);
    model_push(op, x0, x1, y0, y1, col, n);
    @(posedge I_clk); #1;
    scramble();
    bc = 0;
    g = 0;
    while (cmd_ready !== 1'b1 && g < BOUND) begin
      if (busy === 1'b1) bc++;
      @(posedge I_clk); #1;
      g++;
    end
    check("busy_cycles", bc, n);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, x0, x1, y0, y1, n;

    // Reset
    I_rst = 1'b1;
    repeat (3) @(posedge I_clk);
    #1;
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_ie", int'(IE), 0);
    check("rst_addr", int'(ADDRESS), 0);
    check("rst_colour", int'(COLOUR), 0);
    check("rst_busy", int'(busy), 0);
    I_rst = 1'b0;
    mon_en = 1'b1;
    @(posedge I_clk); #1;

    // Directed shapes
    send(0, 5, 100, 3, 60, 2);
    send(1, 10, 8, 2, 1, 3);
    send(3, 1, 2, 3, 4, 1);
    check("rsvd_ready_next", int'(cmd_ready), 1);
    send(2, 77, 3, 9, 40, 1);
    send(1, 127, 127, 63, 62, 2);

    // Reset during the third write of a 4x4 fill
    wait_ready();
    drive(1, 20, 23, 10, 13, 3);
    model_push(1, 20, 23, 10, 13, 3, n);
    @(posedge I_clk); #1;
    scramble();
    @(posedge I_clk); #1;
    @(posedge I_clk); #1;
    I_rst = 1'b1;
    @(posedge I_clk); #1;
    I_rst = 1'b0;
    check("midrst_ie", int'(IE), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ready", int'(cmd_ready), 1);
    check("midrst_pending", exp_q.size(), 13);
    exp_q.delete();
    send(0, 64, 0, 32, 0, 1);

    // Reset and accept on the same edge: reset wins
    wait_ready();
    drive(1, 0, 3, 0, 3, 2);
    I_rst = 1'b1;
    @(posedge I_clk); #1;
    I_rst = 1'b0;
    scramble();
    check("rstacc_busy", int'(busy), 0);
    @(posedge I_clk); #1;
    check("rstacc_ie", int'(IE), 0);
    check("rstacc_ready", int'(cmd_ready), 1);

    // Randomized commands with random gaps
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 9);
      op = (n < 4) ? 0 : ((n < 9) ? 1 : 3);
      x0 = $urandom_range(0, W - 1);
      x1 = clampi(x0 + $urandom_range(0, 24) - 12, 0, W - 1);
      y0 = $urandom_range(0, H - 1);
      y1 = clampi(y0 + $urandom_range(0, 12) - 6, 0, H - 1);
      send(op, x0, x1, y0, y1, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin
        @(posedge I_clk); #1;
      end
    end

`ifdef FB_DRAW_VBLANK_GATE_EN
    // Vblank gating: paused outside blanking, resumes in order
    chk_ie_busy = 1'b0;
    I_vblank = 1'b0;
    repeat (3) begin
      @(posedge I_clk); #1;
    end
    wait_ready();
    drive(1, 0, 1, 0, 1, 2);
    model_push(1, 0, 1, 0, 1, 2, n);
    @(posedge I_clk); #1;
    scramble();
    repeat (8) begin
      @(posedge I_clk); #1;
    end
    check("gate_no_writes", exp_q.size(), 4);
    check("gate_busy", int'(busy), 1);
    I_vblank = 1'b1;
    @(posedge I_clk); #1;
    check("gate_ie_m", int'(IE), 0);
    @(posedge I_clk); #1;
    check("gate_ie_m1", int'(IE), 0);
    @(posedge I_clk); #1;
    check("gate_ie_m2", int'(IE), 1);
    I_vblank = 1'b0;
    repeat (8) begin
      @(posedge I_clk); #1;
    end
    check("gate_paused_busy", int'(busy), 1);
    check("gate_paused_partial", int'(exp_q.size() > 0 && exp_q.size() < 4), 1);
    I_vblank = 1'b1;
    wait_ready();
    check("gate_drained", exp_q.size(), 0);
    chk_ie_busy = 1'b1;
`endif

    repeat (3) begin
      @(posedge I_clk); #1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
